// File: rtl/led_blink_arbiter.sv
// Round-robin arbiter that shares one active-low status LED between requesters.
// Each grant plays N one-tick blinks followed by a fixed dark gap, all paced by `tick`.
module led_blink_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned COUNT_W   = 4,
    parameter int unsigned GAP_TICKS = 4,
    localparam int unsigned IdW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned GapW     = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*COUNT_W-1:0] count,
    output logic                       nLED,
    output logic                       busy,
    output logic [IdW-1:0]             active_id,
    output logic [NUM_REQ-1:0]         done
);

    typedef enum logic [1:0] {StIdle, StOn, StOff, StGap} state_e;

    state_e             state_q;
    logic [COUNT_W-1:0] rem_q;
    logic [GapW-1:0]    gcnt_q;
    logic [IdW-1:0]     last_q;

    logic               grant_valid;
    logic [IdW-1:0]     grant_id;
    logic [COUNT_W-1:0] grant_count;
    int unsigned        idx;

    // Walk downward so the requester closest after last_q is the final (winning) assignment.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            idx = 32'(last_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx[IdW-1:0]]) begin
                grant_valid = 1'b1;
                grant_id    = idx[IdW-1:0];
            end
        end
    end

    always_comb begin
        grant_count = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IdW'(i)) begin
                grant_count = count[i*COUNT_W +: COUNT_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            gcnt_q    <= '0;
            last_q    <= IdW'(NUM_REQ - 1);
            active_id <= '0;
            nLED      <= 1'b1;
            busy      <= 1'b0;
            done      <= '0;
        end else begin
            done <= '0;
            if (tick) begin
                unique case (state_q)
                    StIdle: begin
                        if (grant_valid) begin
                            active_id <= grant_id;
                            last_q    <= grant_id;
                            busy      <= 1'b1;
                            rem_q     <= grant_count;
                            if (grant_count != '0) begin
                                state_q <= StOn;
                                nLED    <= 1'b0;
                            end else begin
                                state_q <= StGap;
                                gcnt_q  <= GapW'(GAP_TICKS - 1);
                            end
                        end
                    end
                    StOn: begin
                        state_q <= StOff;
                        nLED    <= 1'b1;
                        rem_q   <= rem_q - 1'b1;
                    end
                    StOff: begin
                        if (rem_q != '0) begin
                            state_q <= StOn;
                            nLED    <= 1'b0;
                        end else begin
                            state_q <= StGap;
                            gcnt_q  <= GapW'(GAP_TICKS - 1);
                        end
                    end
                    StGap: begin
                        if (gcnt_q != '0) begin
                            gcnt_q <= gcnt_q - 1'b1;
                        end else begin
                            state_q         <= StIdle;
                            busy            <= 1'b0;
                            done[active_id] <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Bench for led_blink_arbiter: tick-level timeline model checked every clk,
// plus hand-computed expectations for the directed scenarios.
module tb_led_blink_arbiter;

    localparam int NR  = 4;
    localparam int CW  = 4;
    localparam int GAP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tick = 1'b0;
    logic [NR-1:0] req = '0;
    logic [NR*CW-1:0] count = '0;
    logic          nLED;
    logic          busy;
    logic [1:0]    active_id;
    logic [NR-1:0] done;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    led_blink_arbiter #(
        .NUM_REQ  (NR),
        .COUNT_W  (CW),
        .GAP_TICKS(GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .req      (req),
        .count    (count),
        .nLED     (nLED),
        .busy     (busy),
        .active_id(active_id),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a code is a timeline of 2N+GAP ticks after the grant tick; the LED
    // is lit on even offsets below 2N, and done fires when the offset reaches the end.
    int            m_last = NR - 1;
    int            m_id   = 0;
    int            m_n    = 0;
    int            m_t    = 0;
    bit            m_busy = 1'b0;
    logic [NR-1:0] m_done = '0;

    always @(posedge clk) begin
        bit found;
        m_done = '0;
        if (rst) begin
            m_busy = 1'b0;
            m_t    = 0;
            m_id   = 0;
            m_last = NR - 1;
        end else if (tick) begin
            if (!m_busy) begin
                found = 1'b0;
                for (int k = 1; k <= NR; k++) begin
                    int c;
                    c = (m_last + k) % NR;
                    if (!found && req[c]) begin
                        found  = 1'b1;
                        m_busy = 1'b1;
                        m_id   = c;
                        m_last = c;
                        m_n    = int'(count[c*CW +: CW]);
                        m_t    = 0;
                    end
                end
            end else begin
                m_t++;
                if (m_t == 2 * m_n + GAP) begin
                    m_busy       = 1'b0;
                    m_done[m_id] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("nLED", 32'(nLED), 32'(!(m_busy && m_t < 2 * m_n && (m_t % 2) == 0)));
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            if (m_busy) check("active_id", 32'(active_id), 32'(m_id));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
    endtask

    // One tick, then sample the outputs it produced; ticks are 10 clks apart.
    task automatic tick_once(output logic l, output logic b, output logic [NR-1:0] d,
                             output logic [1:0] id);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        l  = nLED;
        b  = busy;
        d  = done;
        id = active_id;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic          l, b;
        logic [NR-1:0] d;
        logic [1:0]    id;
        logic [31:0]   low_mask;
        logic          prev_b;
        int            bad;
        int            grants[$];
        int            dones[$];
        int            done_ticks[$];

        // Reset state
        do_reset();
        check("rst_nLED", 32'(nLED), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_id", 32'(active_id), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // Single code: count0=3
        req = 4'b0001;
        count = '0;
        count[0*CW +: CW] = 4'd3;
        low_mask = '0;
        for (int i = 1; i <= 12; i++) begin
            tick_once(l, b, d, id);
            if (!l) low_mask[i-1] = 1'b1;
            if (i == 1) check("single_busy_t1", 32'(b), 32'd1);
            if (i == 10) check("single_done_t10", 32'(d), 32'd0);
            if (i == 11) begin
                check("single_done_t11", 32'(d), 32'b0001);
                check("single_busy_t11", 32'(b), 32'd0);
            end
        end
        check("single_low_mask", low_mask & 32'h7ff, 32'h015);

        // Zero count on requester 1
        do_reset();
        req = 4'b0010;
        count = '0;
        low_mask = '0;
        for (int i = 1; i <= 6; i++) begin
            tick_once(l, b, d, id);
            if (!l) low_mask[i-1] = 1'b1;
            if (i == 1) check("zero_id_t1", 32'(id), 32'd1);
            if (i == 4) check("zero_done_t4", 32'(d), 32'd0);
            if (i == 5) check("zero_done_t5", 32'(d), 32'b0010);
        end
        check("zero_low_mask", low_mask, 32'd0);
        req = '0;

        // Round-robin with all requests held, all counts 1
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < NR; i++) count[i*CW +: CW] = 4'd1;
        prev_b = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick_once(l, b, d, id);
            if (b && !prev_b) grants.push_back(int'(id));
            if (d != '0) begin
                dones.push_back(int'(d));
                done_ticks.push_back(i);
            end
            prev_b = b;
        end
        check("rr_num_grants", 32'(grants.size()), 32'd5);
        check("rr_num_dones", 32'(dones.size()), 32'd4);
        for (int i = 0; i < 5; i++) begin
            if (i < grants.size()) check("rr_grant", 32'(grants[i]), 32'(i % NR));
        end
        for (int i = 0; i < 4; i++) begin
            if (i < dones.size()) begin
                check("rr_done_val", 32'(dones[i]), 32'(1 << i));
                check("rr_done_tick", 32'(done_ticks[i]), 32'(7 + 7 * i));
            end
        end

        // Inputs changed after grant are ignored
        do_reset();
        req = 4'b0100;
        count = '0;
        count[2*CW +: CW] = 4'd2;
        low_mask = '0;
        for (int i = 1; i <= 10; i++) begin
            tick_once(l, b, d, id);
            if (i == 1) begin
                count[2*CW +: CW] = 4'd7;
                req = '0;
            end
            if (!l) low_mask[i-1] = 1'b1;
            if (i == 9) check("late_done_t9", 32'(d), 32'b0100);
        end
        check("late_low_mask", low_mask, 32'b101);

        // Reset mid-blink, with a coincident tick
        do_reset();
        req = 4'b0001;
        count = '0;
        count[0*CW +: CW] = 4'd5;
        tick_once(l, b, d, id);
        check("midrst_on", 32'(l), 32'd0);
        @(negedge clk);
        rst  = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        tick = 1'b0;
        check("midrst_nLED", 32'(nLED), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        req = 4'b1001;
        tick_once(l, b, d, id);
        check("midrst_grant0", 32'(id), 32'd0);
        do_reset();
        req = 4'b1000;
        tick_once(l, b, d, id);
        check("midrst_grant3", 32'(id), 32'd3);

        // No ticks: nothing may happen
        do_reset();
        req = 4'b1111;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (nLED !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("no_tick_quiet", 32'(bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_blink_arbiter.md
Name: led_blink_arbiter

Overview:
- Shares the single board status LED between NUM_REQ requesters, each asking to flash a numeric blink code (N blinks, then a pause).
- Timing comes from the one-cycle `tick` strobe that clockDividerHertz emits on dividedPulse; all LED timing is counted in ticks.
- Arbitration is round-robin. The block sits between status sources (UART, config, error logic) and the active-low LED pin.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- COUNT_W, 4, width of each requested blink count.
- GAP_TICKS, 4, ticks of extra dark time after the last blink (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-clk pulse from the clock divider; the LED time base.
- req  in  NUM_REQ  per-requester request level.
- count  in  NUM_REQ*COUNT_W  blink count; requester i uses bits [i*COUNT_W +: COUNT_W].
- nLED  out  1  LED drive, active low.
- busy  out  1  high while a code is being played.
- active_id  out  clog2(NUM_REQ) (min 1)  index of the granted requester; valid while busy.
- done  out  NUM_REQ  one-hot, one-clk pulse when requester i's code completes.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, nLED=1, busy=0, active_id=0, done=0.
  - RR pointer last=NUM_REQ-1, so req[0] has top priority after reset.
  - Applies mid-sequence too: the sequence is aborted and no done pulse is issued. A tick coincident with rst is ignored.
- State changes only on clk edges where tick=1; between ticks all state holds. All outputs are registered.
- IDLE (nLED=1, busy=0):
  - On tick with any req high, grant the first requester set in req, searching from last+1 upward with wrap.
  - On grant: latch rem=count[grant], active_id=grant, last=grant, busy=1.
  - If rem!=0, go to ON; else go to GAP with gcnt=GAP_TICKS-1.
  - No req on the tick: stay in IDLE.
- ON (nLED=0): on tick, go to OFF with rem=rem-1.
- OFF (nLED=1): on tick, go to ON if rem!=0; else go to GAP with gcnt=GAP_TICKS-1.
- GAP (nLED=1): on tick, if gcnt!=0 then gcnt=gcnt-1; else go to IDLE, busy=0, done[active_id]=1 for exactly one clk.
- Per-code timing: count=N>0 gives N one-tick LED-on pulses, each followed by one dark tick, then GAP_TICKS further dark ticks. Total is 2N+GAP_TICKS ticks from grant to done. count=0 gives GAP_TICKS dark ticks only, then done.
- Inputs sampled only at grant:
  - count changes after grant are ignored.
  - Dropping req mid-sequence does not abort; done still pulses.
  - A req held high after its done is re-arbitrated normally. With other requesters pending, the RR pointer excludes it until they are served.
- A new grant happens no earlier than the tick after done, so there is always at least one IDLE interval between codes.
- count width arithmetic: rem is COUNT_W bits, never decremented below 0. The maximum code is 2^COUNT_W-1 blinks.

Test Plan:
- Single code: GAP_TICKS=4; req[0]=1, count0=3, other reqs 0; 12 ticks spaced 10 clks -> nLED low after ticks 1, 3 and 5 only (one tick each). busy goes high at tick 1. done=0001 for one clk at tick 11, then busy=0.
- Zero count: count1=0, req[1] only -> nLED stays 1. done=0010 at tick 5 (tick 1 grant + GAP_TICKS).
- Round-robin: req=1111 held, all counts=1 -> grant order 0,1,2,3,0 (checked via active_id at each busy rise). done pulses in the same order, each 6 ticks apart plus one idle tick.
- Input changes after grant: req[2] with count2=2; change count2 to 7 and drop req[2] after grant -> exactly 2 blinks, then done=0100.
- Reset mid-blink: assert rst for one clk while in ON -> next cycle nLED=1, busy=0, done=0. The next tick with req[3]=1 grants requester 0 if req[0] is set, otherwise 3 (pointer reset).
- No ticks: req=1111 with tick held 0 for 1000 clks -> nLED=1, busy=0 throughout.
